// File: rtl/sif_fxp_mult.sv
// sif_fxp_mult -- pipelined signed fixed-point multiplier with a joined
// two-operand handshake and a ready/valid product output.
//
// The full 2*WIDTH product is optionally rounded half-up, shifted right by
// FRAC, then saturated or wrapped to WIDTH bits. The result passes through
// LATENCY register stages. The whole pipe moves together on en.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   A_vld/A_dat/A_rdy     operand A handshake
//   B_vld/B_dat/B_rdy     operand B handshake; A and B are consumed together
//   P_vld/P_dat/P_rdy     product handshake (registered outputs)
//   P_ovf                 overflow flag for the current P_dat
//   ovf_sticky, ovf_clr   overflow-seen flag and its synchronous clear
module sif_fxp_mult #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int LATENCY  = 3,
    parameter int ROUND    = 1,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A_vld,
    input  logic [WIDTH-1:0] A_dat,
    output logic             A_rdy,
    input  logic             B_vld,
    input  logic [WIDTH-1:0] B_dat,
    output logic             B_rdy,
    output logic             P_vld,
    output logic [WIDTH-1:0] P_dat,
    input  logic             P_rdy,
    output logic             P_ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    generate
        if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
            $error("sif_fxp_mult: WIDTH must be 8..32");
        end
        if (FRAC < 0 || FRAC > WIDTH - 1) begin : g_bad_frac
            $error("sif_fxp_mult: FRAC must be 0..WIDTH-1");
        end
        if (LATENCY < 1 || LATENCY > 6) begin : g_bad_lat
            $error("sif_fxp_mult: LATENCY must be 1..6");
        end
        if (ROUND < 0 || ROUND > 1) begin : g_bad_round
            $error("sif_fxp_mult: ROUND must be 0 or 1");
        end
        if (SATURATE < 0 || SATURATE > 1) begin : g_bad_sat
            $error("sif_fxp_mult: SATURATE must be 0 or 1");
        end
    endgenerate

    localparam int PW  = 2 * WIDTH + 1;   // product plus one guard bit for the rounding add
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW-1:0] C_RND = (ROUND != 0 && FRAC > 0) ? (PW'(1) << RSH) : '0;
    localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [LATENCY:1]  r_vld;
    logic [WIDTH-1:0]  r_dat [1:LATENCY];
    logic [LATENCY:1]  r_ovf;
    logic              r_sticky;

    logic              w_en;
    logic              w_acc;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [PW-1:0]      w_rnd;
    logic signed [PW-1:0]      w_shr;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_res;
    logic              w_set;

    // Reset forces en low so neither ready can rise while rst is held.
    assign w_en  = !rst && (!r_vld[LATENCY] || P_rdy);
    assign w_acc = A_vld && B_vld && w_en;
    assign A_rdy = w_en && B_vld;
    assign B_rdy = w_en && A_vld;

    assign w_prod = $signed(A_dat) * $signed(B_dat);
    assign w_rnd  = $signed({w_prod[2*WIDTH-1], w_prod}) + $signed(C_RND);
    assign w_shr  = w_rnd >>> FRAC;
    // In range only if every bit from WIDTH-1 upward matches the sign.
    assign w_ovf  = (w_shr[PW-1:WIDTH-1] != {(WIDTH+2){w_shr[PW-1]}});

    always_comb begin
        w_res = w_shr[WIDTH-1:0];
        if (w_ovf && SATURATE != 0)
            w_res = w_shr[PW-1] ? C_MIN : C_MAX;
    end

    // Data stages load on every enabled edge; bubbles carry don't-care data
    // that is never exposed because its valid bit is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int i = 1; i <= LATENCY; i++) r_dat[i] <= '0;
        end else if (w_en) begin
            r_vld[1] <= w_acc;
            r_dat[1] <= w_res;
            r_ovf[1] <= w_ovf;
            for (int i = 2; i <= LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
                r_ovf[i] <= r_ovf[i-1];
            end
        end
    end

    // A new overflow transfer beats a coincident clear.
    assign w_set = r_vld[LATENCY] && P_rdy && r_ovf[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_sticky <= 1'b0;
        else if (w_set)   r_sticky <= 1'b1;
        else if (ovf_clr) r_sticky <= 1'b0;
    end

    assign P_vld      = r_vld[LATENCY];
    assign P_dat      = r_dat[LATENCY];
    assign P_ovf      = r_ovf[LATENCY];
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_sif_fxp_mult.sv
// Bench for sif_fxp_mult: three instances share the operand inputs
// (L3 round/sat, L1 trunc/wrap, L6 round/wrap), each with its own P_rdy.
// A negedge scoreboard predicts every result from plain integer arithmetic.
module tb_sif_fxp_mult;

  localparam int LAT [3] = '{3, 1, 6};
  localparam int RND [3] = '{1, 0, 1};
  localparam int SAT [3] = '{1, 0, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        a_vld, b_vld, ovf_clr;
  logic [15:0] a_dat, b_dat;
  logic [2:0]  a_rdy, b_rdy, p_vld, p_ovf, sticky, p_rdy;
  logic [15:0] p_dat [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_acc [3];
  int cnt_xfer [3];
  logic [16:0] sbq [3][$];
  bit          hold [3];
  logic [16:0] hdat [3];

  always #5 clk = ~clk;

  sif_fxp_mult #(.WIDTH(16), .FRAC(8), .LATENCY(3), .ROUND(1), .SATURATE(1)) u_l3 (
    .clk(clk), .rst(rst), .A_vld(a_vld), .A_dat(a_dat), .A_rdy(a_rdy[0]),
    .B_vld(b_vld), .B_dat(b_dat), .B_rdy(b_rdy[0]), .P_vld(p_vld[0]), .P_dat(p_dat[0]),
    .P_rdy(p_rdy[0]), .P_ovf(p_ovf[0]), .ovf_sticky(sticky[0]), .ovf_clr(ovf_clr));

  sif_fxp_mult #(.WIDTH(16), .FRAC(8), .LATENCY(1), .ROUND(0), .SATURATE(0)) u_l1 (
    .clk(clk), .rst(rst), .A_vld(a_vld), .A_dat(a_dat), .A_rdy(a_rdy[1]),
    .B_vld(b_vld), .B_dat(b_dat), .B_rdy(b_rdy[1]), .P_vld(p_vld[1]), .P_dat(p_dat[1]),
    .P_rdy(p_rdy[1]), .P_ovf(p_ovf[1]), .ovf_sticky(sticky[1]), .ovf_clr(ovf_clr));

  sif_fxp_mult #(.WIDTH(16), .FRAC(8), .LATENCY(6), .ROUND(1), .SATURATE(0)) u_l6 (
    .clk(clk), .rst(rst), .A_vld(a_vld), .A_dat(a_dat), .A_rdy(a_rdy[2]),
    .B_vld(b_vld), .B_dat(b_dat), .B_rdy(b_rdy[2]), .P_vld(p_vld[2]), .P_dat(p_dat[2]),
    .P_rdy(p_rdy[2]), .P_ovf(p_ovf[2]), .ovf_sticky(sticky[2]), .ovf_clr(ovf_clr));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[u%0d] observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  // Reference: exact integer product, optional +0.5 LSB, floor shift, range clamp/wrap.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input int i);
    longint p, q;
    logic [15:0] d;
    p = longint'($signed(a)) * longint'($signed(b));
    if (RND[i] != 0) p = p + 128;
    q = p >>> 8;
    d = q[15:0];
    if (q > 32767) return {1'b1, (SAT[i] != 0) ? 16'h7FFF : d};
    if (q < -32768) return {1'b1, (SAT[i] != 0) ? 16'h8000 : d};
    return {1'b0, d};
  endfunction

  // Scoreboard and protocol monitor; inputs only change just after posedge,
  // so values seen here decide the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        sbq[i].delete();
        hold[i] = 1'b0;
      end else begin
        logic en_e;
        logic [16:0] e;
        en_e = !p_vld[i] || p_rdy[i];
        chk("a_rdy", i, a_rdy[i], en_e && b_vld);
        chk("b_rdy", i, b_rdy[i], en_e && a_vld);
        if (hold[i]) begin
          chk("held_vld", i, p_vld[i], 1'b1);
          chk("held_dat", i, {p_ovf[i], p_dat[i]}, hdat[i]);
        end
        if (p_vld[i] && p_rdy[i]) begin
          cnt_xfer[i]++;
          chk("result_expected", i, sbq[i].size() > 0, 1'b1);
          if (sbq[i].size() > 0) begin
            e = sbq[i].pop_front();
            chk("result", i, {p_ovf[i], p_dat[i]}, e);
          end
        end
        if (a_vld && b_vld && en_e) begin
          sbq[i].push_back(model(a_dat, b_dat, i));
          cnt_acc[i]++;
        end
        hold[i] = p_vld[i] && !p_rdy[i];
        hdat[i] = {p_ovf[i], p_dat[i]};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operand pair with all sinks ready: checks exact latency and value.
  task automatic vec(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                     input logic ovf);
    logic [15:0] ex [3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    a_dat = a; b_dat = b; a_vld = 1'b1; b_vld = 1'b1;
    step();
    a_vld = 1'b0; b_vld = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) step();
      for (int i = 0; i < 3; i++) begin
        chk("lat_vld", i, p_vld[i], k == LAT[i]);
        if (k == LAT[i]) chk("vec_dat", i, {p_ovf[i], p_dat[i]}, {ovf, ex[i]});
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int n, base, cyc;
    bit acc;
    for (int i = 0; i < 3; i++) begin cnt_acc[i] = 0; cnt_xfer[i] = 0; hold[i] = 0; end
    rst = 1'b1; ovf_clr = 1'b0; p_rdy = 3'b111;
    a_vld = 1'b1; b_vld = 1'b1; a_dat = 16'h1234; b_dat = 16'h5678;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_vld", i, p_vld[i], 1'b0);
      chk("rst_dat", i, p_dat[i], 16'h0);
      chk("rst_ovf", i, p_ovf[i], 1'b0);
      chk("rst_sticky", i, sticky[i], 1'b0);
      chk("rst_a_rdy", i, a_rdy[i], 1'b0);
      chk("rst_b_rdy", i, b_rdy[i], 1'b0);
    end
    a_vld = 1'b0; b_vld = 1'b0;
    rst = 1'b0;

    // Directed arithmetic, including rounding direction and both overflow signs.
    vec(16'h0180, 16'h0200, 16'h0300, 16'h0300, 16'h0300, 1'b0);
    vec(16'hFF00, 16'h0180, 16'hFE80, 16'hFE80, 16'hFE80, 1'b0);
    vec(16'h0001, 16'h0080, 16'h0001, 16'h0000, 16'h0001, 1'b0);
    vec(16'hFFFF, 16'h0080, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) chk("sticky_clean", i, sticky[i], 1'b0);
    vec(16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 1'b1);
    vec(16'h8000, 16'h7FFF, 16'h8000, 16'h0080, 16'h0080, 1'b1);
    step();
    for (int i = 0; i < 3; i++) chk("sticky_set", i, sticky[i], 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    for (int i = 0; i < 3; i++) chk("sticky_clr", i, sticky[i], 1'b0);

    // Backpressure on the L3 instance: 8 pairs, sink blocked.
    p_rdy = 3'b110;
    n = 0;
    base = cnt_xfer[0];
    a_dat = 16'($urandom); b_dat = 16'($urandom);
    for (int c = 0; c < 12; c++) begin
      a_vld = 1'b1; b_vld = 1'b1;
      acc = !p_vld[0] || p_rdy[0];
      step();
      if (acc) begin n++; a_dat = 16'($urandom); b_dat = 16'($urandom); end
    end
    chk("bp_accepted", 0, n, 3);
    chk("bp_vld", 0, p_vld[0], 1'b1);
    chk("bp_a_rdy", 0, a_rdy[0], 1'b0);
    chk("bp_b_rdy", 0, b_rdy[0], 1'b0);
    cyc = 0;
    while ((n < 8 || cnt_xfer[0] - base < 8) && cyc < 300) begin
      a_vld = (n < 8); b_vld = (n < 8);
      p_rdy[0] = 1'($urandom_range(0, 1));
      acc = a_vld && b_vld && (!p_vld[0] || p_rdy[0]);
      step();
      if (acc) begin n++; a_dat = 16'($urandom); b_dat = 16'($urandom); end
      cyc++;
    end
    a_vld = 1'b0; b_vld = 1'b0; p_rdy = 3'b111;
    step(); step();
    chk("bp_transfers", 0, cnt_xfer[0] - base, 8);
    repeat (8) step();

    // Join: A waits alone for 4 cycles, then 3 cycles with both valid.
    base = cnt_acc[0];
    a_vld = 1'b1; b_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("join_a_rdy", 0, a_rdy[0], 1'b0);
      step();
      chk("join_no_out", 0, p_vld[0], 1'b0);
    end
    chk("join_no_acc", 0, cnt_acc[0] - base, 0);
    b_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_dat = 16'($urandom); b_dat = 16'($urandom);
      step();
    end
    a_vld = 1'b0; b_vld = 1'b0;
    step();
    chk("join_acc", 0, cnt_acc[0] - base, 3);
    repeat (8) step();

    // Random traffic with independent sink stalls on all three instances.
    for (int c = 0; c < 400; c++) begin
      a_vld = 1'($urandom_range(0, 3) != 0);
      b_vld = 1'($urandom_range(0, 3) != 0);
      a_dat = 16'($urandom); b_dat = 16'($urandom);
      p_rdy = 3'($urandom);
      step();
    end
    a_vld = 1'b0; b_vld = 1'b0; p_rdy = 3'b111;
    repeat (10) step();
    for (int i = 0; i < 3; i++) chk("drain_empty", i, sbq[i].size(), 0);

    // Reset with results in flight.
    for (int c = 0; c < 3; c++) begin
      a_vld = 1'b1; b_vld = 1'b1;
      a_dat = 16'($urandom); b_dat = 16'($urandom);
      step();
    end
    a_vld = 1'b0; b_vld = 1'b0;
    chk("pre_rst_vld", 0, p_vld[0], 1'b1);
    a_vld = 1'b1; b_vld = 1'b1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_vld", i, p_vld[i], 1'b0);
      chk("mid_rst_a_rdy", i, a_rdy[i], 1'b0);
    end
    step(); step();
    a_vld = 1'b0; b_vld = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < 3; i++) chk("post_rst_vld", i, p_vld[i], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
